// File: rtl/pdp8_banked_memory_controller_if.sv
// Request/response bus between the PDP-8 datapath (master) and the banked memory controller (slave).
interface pdp8_banked_memory_controller_if #(
  parameter int WORD_WIDTH = 12,
  parameter int ADDR_WIDTH = 12,
  parameter int FIELD_BITS = 3
);
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_kind;
  logic [FIELD_BITS-1:0] req_field;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [WORD_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [WORD_WIDTH-1:0] resp_rdata;
  logic [1:0]            resp_err;
  logic [31:0]           stat_if;
  logic [31:0]           stat_dr;
  logic [31:0]           stat_dw;

  modport master (
    output req_valid, req_kind, req_field, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stat_if, stat_dr, stat_dw
  );

  modport slave (
    input  req_valid, req_kind, req_field, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stat_if, stat_dr, stat_dw
  );
endinterface

// File: rtl/pdp8_banked_memory_controller.sv
// Banked PDP-8 main memory: one outstanding request, fixed LATENCY, per-word init tracking.
// Optional access counters are built only when MEM_STATS_EN is defined.
module pdp8_banked_memory_controller #(
  parameter int WORD_WIDTH = 12,
  parameter int ADDR_WIDTH = 12,
  parameter int FIELD_BITS = 3,
  parameter int LATENCY    = 1
) (
  input  logic clk,
  input  logic reset,
  pdp8_banked_memory_controller_if.slave bus
);
  localparam int IDX_W = FIELD_BITS + ADDR_WIDTH;
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] K_DR = 2'b00;
  localparam logic [1:0] K_IF = 2'b01;
  localparam logic [1:0] K_DW = 2'b10;

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic [1:0]            kind_q;
  logic [IDX_W-1:0]      idx_q;
  logic [WORD_WIDTH-1:0] wdata_q;
  logic [WORD_WIDTH-1:0] rdata_q, rd_now;
  logic [1:0]            err_q, err_now;
  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      vld;
  logic                  accept, in_resp, commit;

  assign accept  = (state == ST_IDLE) && bus.req_valid;
  assign in_resp = (state == ST_RESP);
  assign commit  = in_resp && (kind_q == K_DW);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      kind_q  <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.req_valid) begin
          kind_q  <= bus.req_kind;
          idx_q   <= {bus.req_field, bus.req_addr};
          wdata_q <= bus.req_wdata;
          cnt     <= LAT_M1;
          state   <= (LATENCY == 1) ? ST_RESP : ST_BUSY;
        end
        ST_BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= ST_RESP;
        end
        ST_RESP: begin
          rdata_q <= rd_now;
          err_q   <= err_now;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) vld <= '0;
    else if (commit) vld[idx_q] <= 1'b1;
  end

  // Reset gates the store so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (!reset && commit) mem[idx_q] <= wdata_q;
  end

  always_comb begin
    rd_now  = '0;
    err_now = 2'b00;
    case (kind_q)
      K_DR, K_IF: begin
        if (vld[idx_q]) rd_now = mem[idx_q];
        else            err_now = 2'b01;
      end
      K_DW:    err_now = 2'b00;
      default: err_now = 2'b10;
    endcase
  end

  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.resp_valid = in_resp;
  assign bus.resp_rdata = in_resp ? rd_now  : rdata_q;
  assign bus.resp_err   = in_resp ? err_now : err_q;

`ifdef MEM_STATS_EN
  logic [31:0] c_if, c_dr, c_dw;

  always_ff @(posedge clk) begin
    if (reset) begin
      c_if <= '0;
      c_dr <= '0;
      c_dw <= '0;
    end else if (accept) begin
      case (bus.req_kind)
        K_IF:    if (c_if != 32'hFFFF_FFFF) c_if <= c_if + 32'd1;
        K_DR:    if (c_dr != 32'hFFFF_FFFF) c_dr <= c_dr + 32'd1;
        K_DW:    if (c_dw != 32'hFFFF_FFFF) c_dw <= c_dw + 32'd1;
        default: ;
      endcase
    end
  end

  assign bus.stat_if = c_if;
  assign bus.stat_dr = c_dr;
  assign bus.stat_dw = c_dw;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign bus.stat_if = '0;
  assign bus.stat_dr = '0;
  assign bus.stat_dw = '0;
`endif
endmodule

// File: tb/tb_pdp8_banked_memory_controller.sv
// Directed bench: one controller at LATENCY=4 (main checks) and one at LATENCY=1.
module tb_pdp8_banked_memory_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   e_if = 0, e_dr = 0, e_dw = 0;

  always #5 clk = ~clk;

  pdp8_banked_memory_controller_if bus4 ();
  pdp8_banked_memory_controller_if bus1 ();

  pdp8_banked_memory_controller #(.LATENCY(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  pdp8_banked_memory_controller #(.LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic [1:0] k,
                       input logic [2:0] f, input logic [11:0] a, input logic [11:0] w);
    if (sel) begin
      bus4.req_valid = v; bus4.req_kind = k; bus4.req_field = f;
      bus4.req_addr = a;  bus4.req_wdata = w;
    end else begin
      bus1.req_valid = v; bus1.req_kind = k; bus1.req_field = f;
      bus1.req_addr = a;  bus1.req_wdata = w;
    end
  endtask

  function automatic logic rv(input bit sel);
    return sel ? bus4.resp_valid : bus1.resp_valid;
  endfunction

  function automatic logic rdy(input bit sel);
    return sel ? bus4.req_ready : bus1.req_ready;
  endfunction

  // sel=1 targets the LATENCY=4 instance; returns at the negedge of the response cycle.
  task automatic txn(input string tag, input bit sel, input logic [1:0] k, input logic [2:0] f,
                     input logic [11:0] a, input logic [11:0] w,
                     output logic [11:0] rd, output logic [1:0] er);
    int lat, hit;
    logic busy_ok;
    lat = sel ? 4 : 1;
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(rdy(sel)), 32'd1);
    drive(sel, 1'b1, k, f, a, w);
    @(posedge clk); #1;
    drive(sel, 1'b0, k, f, a, w);
    if (sel) begin
      if (k == 2'b01) e_if++;
      else if (k == 2'b00) e_dr++;
      else if (k == 2'b10) e_dw++;
    end
    hit = 0;
    busy_ok = 1'b1;
    for (int i = 1; i <= lat + 3 && hit == 0; i++) begin
      @(negedge clk);
      if (rdy(sel)) busy_ok = 1'b0;
      if (rv(sel)) hit = i;
    end
    chk({tag, "_lat"}, 32'(hit), 32'(lat));
    chk({tag, "_busy"}, 32'(busy_ok), 32'd1);
    rd = sel ? bus4.resp_rdata : bus1.resp_rdata;
    er = sel ? bus4.resp_err : bus1.resp_err;
  endtask

  task automatic chk_stats(input string tag);
`ifdef MEM_STATS_EN
    chk({tag, "_if"}, bus4.stat_if, 32'(e_if));
    chk({tag, "_dr"}, bus4.stat_dr, 32'(e_dr));
    chk({tag, "_dw"}, bus4.stat_dw, 32'(e_dw));
`else
    chk({tag, "_if"}, bus4.stat_if, 32'd0);
    chk({tag, "_dr"}, bus4.stat_dr, 32'd0);
    chk({tag, "_dw"}, bus4.stat_dw, 32'd0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    e_if = 0; e_dr = 0; e_dw = 0;
  endtask

  initial begin
    logic [11:0] rd;
    logic [1:0]  er;
    int pulses;

    drive(1'b1, 1'b0, 2'b00, 3'd0, 12'd0, 12'd0);
    drive(1'b0, 1'b0, 2'b00, 3'd0, 12'd0, 12'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus4.req_ready), 32'd1);
    chk("rst_rv", 32'(bus4.resp_valid), 32'd0);
    chk("rst_rdata", 32'(bus4.resp_rdata), 32'd0);
    chk("rst_err", 32'(bus4.resp_err), 32'd0);
    chk_stats("rst_stat");
    reset = 1'b0;

    // Uninitialised reads on both latencies
    txn("rd0_l1", 1'b0, 2'b00, 3'd0, 12'o0000, 12'd0, rd, er);
    chk("rd0_l1_data", 32'(rd), 32'd0);
    chk("rd0_l1_err", 32'(er), 32'd1);
    txn("rd0_l4", 1'b1, 2'b00, 3'd0, 12'o0000, 12'd0, rd, er);
    chk("rd0_l4_data", 32'(rd), 32'd0);
    chk("rd0_l4_err", 32'(er), 32'd1);

    // Write then fetch, field isolation
    txn("wr3", 1'b1, 2'b10, 3'd3, 12'o1234, 12'o7777, rd, er);
    chk("wr3_data", 32'(rd), 32'd0);
    chk("wr3_err", 32'(er), 32'd0);
    txn("if3", 1'b1, 2'b01, 3'd3, 12'o1234, 12'd0, rd, er);
    chk("if3_data", 32'(rd), 32'(12'o7777));
    chk("if3_err", 32'(er), 32'd0);
    @(negedge clk);
    chk("post_rv", 32'(bus4.resp_valid), 32'd0);
    chk("post_ready", 32'(bus4.req_ready), 32'd1);
    chk("hold_data", 32'(bus4.resp_rdata), 32'(12'o7777));
    chk("hold_err", 32'(bus4.resp_err), 32'd0);
    txn("if2", 1'b1, 2'b01, 3'd2, 12'o1234, 12'd0, rd, er);
    chk("if2_data", 32'(rd), 32'd0);
    chk("if2_err", 32'(er), 32'd1);

    // Top-of-memory index on the LATENCY=1 instance
    txn("wr7_l1", 1'b0, 2'b10, 3'd7, 12'o7777, 12'o5252, rd, er);
    txn("rd7_l1", 1'b0, 2'b00, 3'd7, 12'o7777, 12'd0, rd, er);
    chk("rd7_l1_data", 32'(rd), 32'(12'o5252));
    chk("rd7_l1_err", 32'(er), 32'd0);
    txn("rd6_l1", 1'b0, 2'b00, 3'd6, 12'o7777, 12'd0, rd, er);
    chk("rd6_l1_err", 32'(er), 32'd1);
    chk_stats("mid_stat");

    // Reset during BUSY of a second write aborts it
    txn("wr0", 1'b1, 2'b10, 3'd0, 12'o0200, 12'o0042, rd, er);
    @(negedge clk);
    drive(1'b1, 1'b1, 2'b10, 3'd0, 12'o0200, 12'o1111);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 2'b10, 3'd0, 12'o0200, 12'o1111);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    e_if = 0; e_dr = 0; e_dw = 0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus4.resp_valid) pulses++;
    end
    chk("abort_resp", 32'(pulses), 32'd0);
    chk("abort_ready", 32'(bus4.req_ready), 32'd1);
    txn("rd200", 1'b1, 2'b00, 3'd0, 12'o0200, 12'd0, rd, er);
    chk("rd200_data", 32'(rd), 32'd0);
    chk("rd200_err", 32'(er), 32'd1);

    // Reserved kind leaves memory untouched
    txn("wr1", 1'b1, 2'b10, 3'd1, 12'o0005, 12'o1234, rd, er);
    txn("bad", 1'b1, 2'b11, 3'd1, 12'o0005, 12'o7777, rd, er);
    chk("bad_data", 32'(rd), 32'd0);
    chk("bad_err", 32'(er), 32'd2);
    txn("rd1", 1'b1, 2'b00, 3'd1, 12'o0005, 12'd0, rd, er);
    chk("rd1_data", 32'(rd), 32'(12'o1234));
    chk("rd1_err", 32'(er), 32'd0);

    // req_valid held through BUSY yields exactly one accept
    @(negedge clk);
    drive(1'b1, 1'b1, 2'b00, 3'd1, 12'o0005, 12'd0);
    e_dr++;
    pulses = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (bus4.resp_valid) pulses++;
    end
    drive(1'b1, 1'b0, 2'b00, 3'd1, 12'o0005, 12'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus4.resp_valid) pulses++;
    end
    chk("hold_valid_pulses", 32'(pulses), 32'd1);
    chk_stats("pre_stat");

    // Counter sequence from a clean reset
    do_reset();
    chk_stats("clr_stat");
    for (int i = 0; i < 3; i++) txn("s_if", 1'b1, 2'b01, 3'd3, 12'o1234, 12'd0, rd, er);
    for (int i = 0; i < 2; i++) txn("s_dr", 1'b1, 2'b00, 3'd3, 12'o1234, 12'd0, rd, er);
    txn("s_dw", 1'b1, 2'b10, 3'd4, 12'o0001, 12'o0017, rd, er);
    txn("s_bad", 1'b1, 2'b11, 3'd4, 12'o0001, 12'd0, rd, er);
    @(negedge clk);
`ifdef MEM_STATS_EN
    chk("fin_if", bus4.stat_if, 32'd3);
    chk("fin_dr", bus4.stat_dr, 32'd2);
    chk("fin_dw", bus4.stat_dw, 32'd1);
`else
    chk("fin_if", bus4.stat_if, 32'd0);
    chk("fin_dr", bus4.stat_dr, 32'd0);
    chk("fin_dw", bus4.stat_dw, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
